// File: rtl/execute_stage_mc.sv
// Execute stage: operand/forwarding muxes, single-cycle ALU, CCR flags and an
// iterative shift-add multiplier / restoring divider that stalls via busy.
module execute_stage_mc #(
    parameter int W         = 16,
    parameter int SHAMT_W   = 4,
    parameter bit MULDIV_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [3:0]         op,
    input  logic [1:0]         src_sel,
    input  logic               dst_sel,
    input  logic [1:0]         fu_src_sel,
    input  logic [1:0]         fu_dst_sel,
    input  logic               flags_we,
    input  logic               flags_restore,
    input  logic [W-1:0]       rsrc,
    input  logic [W-1:0]       rdst,
    input  logic [W-1:0]       imm,
    input  logic [W-1:0]       sp_low,
    input  logic [W-1:0]       in_port,
    input  logic [W-1:0]       fwd_em,
    input  logic [W-1:0]       fwd_mw,
    input  logic [W-1:0]       fwd_wb,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               out_valid,
    output logic [W-1:0]       alu_result,
    output logic [2:0]         flags_out,
    output logic [W-1:0]       sp_before
);
    localparam logic [3:0] OP_NOT  = 4'h1, OP_INC  = 4'h2, OP_DEC  = 4'h3,
                           OP_ADD  = 4'h4, OP_SUB  = 4'h5, OP_AND  = 4'h6,
                           OP_OR   = 4'h7, OP_SHL  = 4'h8, OP_SHR  = 4'h9,
                           OP_SETC = 4'hA, OP_CLRC = 4'hB, OP_MUL  = 4'hC,
                           OP_DIVU = 4'hD;
    localparam logic [W:0]         ONE_X    = (W+1)'(1);
    localparam logic [SHAMT_W-1:0] CNT_LAST = SHAMT_W'(W-1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
    state_t state, state_nx;

    logic [W-1:0]       m1_p0, m2_p0, a_p0, b_p0;
    logic [W-1:0]       alu_res_p0;
    logic [2:0]         alu_flags_p0;
    logic               alu_upd_p0, c_new_p0, keep_nz_p0;
    logic [W:0]         inc_ext, dec_ext, add_ext, sub_ext, shl_ext, shr_ext;
    logic               is_md, accept, start_md, finish_md, load_res;

    logic [W-1:0]       acc_hi_p1, acc_lo_p1, opnd_p1;
    logic               is_div_p1, fwe_p1;
    logic [SHAMT_W-1:0] cnt_p1;
    logic [W:0]         mul_sum, div_trial, div_diff;
    logic               div_ok;
    logic [W-1:0]       mul_hi_n, mul_lo_n, div_hi_n, div_lo_n, md_res;
    logic [2:0]         md_flags;

    // ---- stage p0: operand selection and forwarding ----
    always_comb begin
        case (src_sel)
            2'b00:   m1_p0 = rsrc;
            2'b01:   m1_p0 = in_port;
            2'b10:   m1_p0 = imm;
            default: m1_p0 = sp_low;
        endcase
        m2_p0 = dst_sel ? W'(shamt) : rdst;
        case (fu_src_sel)
            2'b00:   a_p0 = m1_p0;
            2'b01:   a_p0 = fwd_wb;
            2'b10:   a_p0 = fwd_em;
            default: a_p0 = fwd_mw;
        endcase
        case (fu_dst_sel)
            2'b00:   b_p0 = m2_p0;
            2'b01:   b_p0 = fwd_wb;
            2'b10:   b_p0 = fwd_em;
            default: b_p0 = fwd_mw;
        endcase
    end

    assign sp_before = a_p0;
    assign inc_ext   = {1'b0, b_p0} + ONE_X;
    assign dec_ext   = {1'b0, b_p0} - ONE_X;
    assign add_ext   = {1'b0, a_p0} + {1'b0, b_p0};
    assign sub_ext   = {1'b0, b_p0} - {1'b0, a_p0};
    // Bit W of the left shift / bit 0 of the right shift is the last bit shifted out.
    assign shl_ext   = {1'b0, b_p0} << shamt;
    assign shr_ext   = {b_p0, 1'b0} >> shamt;

    always_comb begin
        alu_res_p0 = b_p0;
        c_new_p0   = flags_out[2];
        alu_upd_p0 = 1'b0;
        keep_nz_p0 = 1'b0;
        case (op)
            OP_NOT:  begin alu_res_p0 = ~b_p0; alu_upd_p0 = 1'b1; end
            OP_INC:  begin alu_res_p0 = inc_ext[W-1:0]; c_new_p0 = inc_ext[W]; alu_upd_p0 = 1'b1; end
            OP_DEC:  begin alu_res_p0 = dec_ext[W-1:0]; c_new_p0 = dec_ext[W]; alu_upd_p0 = 1'b1; end
            OP_ADD:  begin alu_res_p0 = add_ext[W-1:0]; c_new_p0 = add_ext[W]; alu_upd_p0 = 1'b1; end
            OP_SUB:  begin alu_res_p0 = sub_ext[W-1:0]; c_new_p0 = sub_ext[W]; alu_upd_p0 = 1'b1; end
            OP_AND:  begin alu_res_p0 = a_p0 & b_p0; alu_upd_p0 = 1'b1; end
            OP_OR:   begin alu_res_p0 = a_p0 | b_p0; alu_upd_p0 = 1'b1; end
            OP_SHL:  begin
                alu_res_p0 = shl_ext[W-1:0];
                if (shamt != '0) c_new_p0 = shl_ext[W];
                alu_upd_p0 = 1'b1;
            end
            OP_SHR:  begin
                alu_res_p0 = shr_ext[W:1];
                if (shamt != '0) c_new_p0 = shr_ext[0];
                alu_upd_p0 = 1'b1;
            end
            OP_SETC: begin c_new_p0 = 1'b1; alu_upd_p0 = 1'b1; keep_nz_p0 = 1'b1; end
            OP_CLRC: begin c_new_p0 = 1'b0; alu_upd_p0 = 1'b1; keep_nz_p0 = 1'b1; end
            // NOP, disabled MUL/DIVU pass B; 1110/1111 pass A; none touch flags.
            default: alu_res_p0 = (op[3:1] == 3'b111) ? a_p0 : b_p0;
        endcase
        alu_flags_p0 = keep_nz_p0 ? {c_new_p0, flags_out[1:0]}
                                  : {c_new_p0, alu_res_p0[W-1], alu_res_p0 == '0};
    end

    // ---- stage p1: iterative multiply / divide step ----
    assign mul_sum   = {1'b0, acc_hi_p1} + (acc_lo_p1[0] ? {1'b0, opnd_p1} : '0);
    assign mul_hi_n  = mul_sum[W:1];
    assign mul_lo_n  = {mul_sum[0], acc_lo_p1[W-1:1]};
    assign div_trial = {acc_hi_p1, acc_lo_p1[W-1]};
    assign div_diff  = div_trial - {1'b0, opnd_p1};
    assign div_ok    = ~div_diff[W];
    assign div_hi_n  = div_ok ? div_diff[W-1:0] : div_trial[W-1:0];
    assign div_lo_n  = {acc_lo_p1[W-2:0], div_ok};
    assign md_res    = is_div_p1 ? div_lo_n : mul_lo_n;
    assign md_flags  = {is_div_p1 ? (opnd_p1 == '0) : (mul_hi_n != '0),
                        md_res[W-1], md_res == '0};
    assign is_md     = MULDIV_EN && ((op == OP_MUL) || (op == OP_DIVU));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start_md) state_nx = S_BUSY;
            S_BUSY:  if (cnt_p1 == '0) state_nx = S_DONE;
            default: state_nx = start_md ? S_BUSY : S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == S_BUSY);
        accept    = in_valid && !busy;
        start_md  = accept && is_md;
        finish_md = busy && (cnt_p1 == '0);
        load_res  = (accept && !is_md) || finish_md;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_p1     <= '0;
            out_valid  <= 1'b0;
            alu_result <= '0;
            flags_out  <= 3'b000;
        end else begin
            out_valid <= load_res;
            if (load_res) alu_result <= finish_md ? md_res : alu_res_p0;
            if (start_md)                   cnt_p1 <= CNT_LAST;
            else if (busy && cnt_p1 != '0)  cnt_p1 <= cnt_p1 - SHAMT_W'(1);
            if (flags_restore)                                flags_out <= fwd_wb[2:0];
            else if (accept && !is_md && flags_we && alu_upd_p0) flags_out <= alu_flags_p0;
            else if (finish_md && fwe_p1)                     flags_out <= md_flags;
        end
    end

    always_ff @(posedge clk) begin
        if (start_md) begin
            opnd_p1   <= a_p0;
            acc_hi_p1 <= '0;
            acc_lo_p1 <= b_p0;
            is_div_p1 <= (op == OP_DIVU);
            fwe_p1    <= flags_we;
        end else if (busy) begin
            acc_hi_p1 <= is_div_p1 ? div_hi_n : mul_hi_n;
            acc_lo_p1 <= is_div_p1 ? div_lo_n : mul_lo_n;
        end
    end
endmodule

// File: tb/tb_execute_stage_mc.sv
// Directed bench for execute_stage_mc: ALU vector table plus multi-cycle,
// flag-restore, reset-abort and MULDIV_EN=0 sequences.
module tb_execute_stage_mc;
    localparam int W = 16;
    localparam int SHAMT_W = 4;
    localparam logic [3:0] NOP = 4'h0, NOT_ = 4'h1, INC = 4'h2, DEC = 4'h3, ADD = 4'h4,
                           SUB = 4'h5, AND_ = 4'h6, OR_ = 4'h7, SHL = 4'h8, SHR = 4'h9,
                           SETC = 4'hA, CLRC = 4'hB, MUL = 4'hC, DIVU = 4'hD, PASSA = 4'hE;

    logic clk = 1'b0, rst = 1'b1;
    logic in_valid = 0, dst_sel = 0, flags_we = 0, flags_restore = 0;
    logic [3:0] op = 0;
    logic [1:0] src_sel = 0, fu_src_sel = 0, fu_dst_sel = 0;
    logic [W-1:0] rsrc = 0, rdst = 0, imm = 0, sp_low = 0, in_port = 0;
    logic [W-1:0] fwd_em = 0, fwd_mw = 0, fwd_wb = 0;
    logic [SHAMT_W-1:0] shamt = 0;
    logic busy, out_valid, busy0, out_valid0;
    logic [W-1:0] alu_result, sp_before, res0, sp0;
    logic [2:0] flags_out, flags0;

    int checks = 0, failures = 0;

    execute_stage_mc #(.W(W), .SHAMT_W(SHAMT_W), .MULDIV_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .op(op), .src_sel(src_sel),
        .dst_sel(dst_sel), .fu_src_sel(fu_src_sel), .fu_dst_sel(fu_dst_sel),
        .flags_we(flags_we), .flags_restore(flags_restore), .rsrc(rsrc), .rdst(rdst),
        .imm(imm), .sp_low(sp_low), .in_port(in_port), .fwd_em(fwd_em), .fwd_mw(fwd_mw),
        .fwd_wb(fwd_wb), .shamt(shamt), .busy(busy), .out_valid(out_valid),
        .alu_result(alu_result), .flags_out(flags_out), .sp_before(sp_before));

    execute_stage_mc #(.W(W), .SHAMT_W(SHAMT_W), .MULDIV_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .op(op), .src_sel(src_sel),
        .dst_sel(dst_sel), .fu_src_sel(fu_src_sel), .fu_dst_sel(fu_dst_sel),
        .flags_we(flags_we), .flags_restore(flags_restore), .rsrc(rsrc), .rdst(rdst),
        .imm(imm), .sp_low(sp_low), .in_port(in_port), .fwd_em(fwd_em), .fwd_mw(fwd_mw),
        .fwd_wb(fwd_wb), .shamt(shamt), .busy(busy0), .out_valid(out_valid0),
        .alu_result(res0), .flags_out(flags0), .sp_before(sp0));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [3:0] op; logic [1:0] ss; logic ds; logic [1:0] fs; logic [1:0] fd; logic we;
        logic [15:0] rsrc; logic [15:0] rdst; logic [15:0] imm; logic [15:0] sp; logic [15:0] inp;
        logic [15:0] em; logic [15:0] mw; logic [15:0] wb; logic [3:0] sh;
        logic [15:0] exp_a; logic [15:0] exp_res; logic [2:0] exp_fl;
    } vec_t;
    localparam int NV = 26;
    vec_t vecs[NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic set_op(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b, input logic we);
        src_sel = 0; dst_sel = 0; fu_src_sel = 0; fu_dst_sel = 0; flags_restore = 0;
        op = o; rsrc = a; rdst = b; flags_we = we; in_valid = 1;
    endtask

    task automatic wait_done(output int edges);
        edges = 1;
        while (!out_valid && edges < 40) begin
            @(posedge clk); #1; edges++;
        end
    endtask

    task automatic run_md(input string nm, input logic [3:0] o, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] er, input logic [2:0] ef);
        int e;
        @(negedge clk); set_op(o, a, b, 1'b1);
        @(posedge clk); #1;
        @(negedge clk); in_valid = 0;
        wait_done(e);
        chk({nm, " latency"}, e, 17);
        chk({nm, " result"}, alu_result, er);
        chk({nm, " flags"}, flags_out, ef);
    endtask

    initial begin
        int e, bcnt, early, ov;
        vecs[0]  = '{op:ADD, we:1, rsrc:16'hFFFF, rdst:16'h0001, exp_a:16'hFFFF, exp_res:16'h0000, exp_fl:3'b101, default:0};
        vecs[1]  = '{op:SUB, we:1, rsrc:16'h0003, rdst:16'h0005, exp_a:16'h0003, exp_res:16'h0002, exp_fl:3'b000, default:0};
        vecs[2]  = '{op:SUB, we:1, rsrc:16'h0005, rdst:16'h0003, exp_a:16'h0005, exp_res:16'hFFFE, exp_fl:3'b110, default:0};
        vecs[3]  = '{op:AND_, we:1, rsrc:16'h00F0, rdst:16'h0F0F, exp_a:16'h00F0, exp_res:16'h0000, exp_fl:3'b101, default:0};
        vecs[4]  = '{op:OR_, we:1, rsrc:16'h8000, rdst:16'h0001, exp_a:16'h8000, exp_res:16'h8001, exp_fl:3'b110, default:0};
        vecs[5]  = '{op:NOT_, we:1, rdst:16'hFFFF, exp_res:16'h0000, exp_fl:3'b101, default:0};
        vecs[6]  = '{op:INC, we:1, rdst:16'h7FFF, exp_res:16'h8000, exp_fl:3'b010, default:0};
        vecs[7]  = '{op:DEC, we:1, rdst:16'h0000, exp_res:16'hFFFF, exp_fl:3'b110, default:0};
        vecs[8]  = '{op:CLRC, we:1, rdst:16'h1234, exp_res:16'h1234, exp_fl:3'b010, default:0};
        vecs[9]  = '{op:SHL, we:1, rdst:16'h8001, sh:4'd1, exp_res:16'h0002, exp_fl:3'b100, default:0};
        vecs[10] = '{op:SHR, we:1, rdst:16'h0002, sh:4'd2, exp_res:16'h0000, exp_fl:3'b101, default:0};
        vecs[11] = '{op:SHL, we:1, rdst:16'h8000, sh:4'd0, exp_res:16'h8000, exp_fl:3'b110, default:0};
        vecs[12] = '{op:CLRC, we:1, rdst:16'h0000, exp_res:16'h0000, exp_fl:3'b010, default:0};
        vecs[13] = '{op:SETC, we:1, rdst:16'h0000, exp_res:16'h0000, exp_fl:3'b110, default:0};
        vecs[14] = '{op:SHL, we:1, rdst:16'h0F00, sh:4'd4, exp_res:16'hF000, exp_fl:3'b010, default:0};
        vecs[15] = '{op:ADD, we:1, ss:2'b10, imm:16'h0010, rdst:16'h0005, exp_a:16'h0010, exp_res:16'h0015, exp_fl:3'b000, default:0};
        vecs[16] = '{op:ADD, we:1, ss:2'b01, inp:16'h0100, rdst:16'h0001, exp_a:16'h0100, exp_res:16'h0101, exp_fl:3'b000, default:0};
        vecs[17] = '{op:ADD, we:1, ds:1'b1, sh:4'd3, rsrc:16'h0001, rdst:16'h7777, exp_a:16'h0001, exp_res:16'h0004, exp_fl:3'b000, default:0};
        vecs[18] = '{op:SUB, we:1, ss:2'b11, sp:16'h0002, rdst:16'h0002, exp_a:16'h0002, exp_res:16'h0000, exp_fl:3'b001, default:0};
        vecs[19] = '{op:NOP, we:1, rdst:16'hBEEF, exp_res:16'hBEEF, exp_fl:3'b001, default:0};
        vecs[20] = '{op:PASSA, we:1, rsrc:16'hABCD, rdst:16'h1111, exp_a:16'hABCD, exp_res:16'hABCD, exp_fl:3'b001, default:0};
        vecs[21] = '{op:ADD, we:0, rsrc:16'hFFFF, rdst:16'h0001, exp_a:16'hFFFF, exp_res:16'h0000, exp_fl:3'b001, default:0};
        vecs[22] = '{op:SUB, we:1, fs:2'b11, fd:2'b11, mw:16'h0005, rsrc:16'h0FFF, rdst:16'h0EEE, exp_a:16'h0005, exp_res:16'h0000, exp_fl:3'b001, default:0};
        vecs[23] = '{op:SUB, we:1, fs:2'b11, fd:2'b10, mw:16'h0005, em:16'h0009, exp_a:16'h0005, exp_res:16'h0004, exp_fl:3'b000, default:0};
        vecs[24] = '{op:SUB, we:1, fs:2'b01, wb:16'h0010, rdst:16'h0030, exp_a:16'h0010, exp_res:16'h0020, exp_fl:3'b000, default:0};
        vecs[25] = '{op:ADD, we:1, fs:2'b10, fd:2'b01, em:16'h0001, wb:16'h0007, exp_a:16'h0001, exp_res:16'h0008, exp_fl:3'b000, default:0};

        repeat (2) @(posedge clk);
        @(negedge clk); rst = 0; #1;
        chk("reset busy", busy, 0);
        chk("reset out_valid", out_valid, 0);
        chk("reset alu_result", alu_result, 0);
        chk("reset flags", flags_out, 0);

        // Back-to-back single-cycle vectors: out_valid must hold high every cycle.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            op = vecs[i].op; src_sel = vecs[i].ss; dst_sel = vecs[i].ds;
            fu_src_sel = vecs[i].fs; fu_dst_sel = vecs[i].fd; flags_we = vecs[i].we;
            rsrc = vecs[i].rsrc; rdst = vecs[i].rdst; imm = vecs[i].imm; sp_low = vecs[i].sp;
            in_port = vecs[i].inp; fwd_em = vecs[i].em; fwd_mw = vecs[i].mw;
            fwd_wb = vecs[i].wb; shamt = vecs[i].sh; flags_restore = 0; in_valid = 1;
            @(posedge clk); #1;
            chk($sformatf("vec%0d out_valid", i), out_valid, 1);
            chk($sformatf("vec%0d result", i), alu_result, vecs[i].exp_res);
            chk($sformatf("vec%0d flags", i), flags_out, vecs[i].exp_fl);
            chk($sformatf("vec%0d sp_before", i), sp_before, vecs[i].exp_a);
        end
        @(negedge clk); in_valid = 0;
        @(posedge clk); #1;
        chk("idle out_valid", out_valid, 0);
        chk("idle result hold", alu_result, 16'h0008);

        // MUL with the next instruction held on in_valid throughout busy.
        @(negedge clk); shamt = 0; set_op(MUL, 16'h0100, 16'h0100, 1'b1);
        @(posedge clk); #1; e = 1;
        @(negedge clk); set_op(ADD, 16'h0001, 16'h0002, 1'b1);
        bcnt = 0; early = 0;
        while (busy && e < 40) begin
            bcnt++;
            if (out_valid) early++;
            @(posedge clk); #1; e++;
        end
        chk("mul busy cycles", bcnt, 16);
        chk("mul early out_valid", early, 0);
        chk("mul latency", e, 17);
        chk("mul out_valid", out_valid, 1);
        chk("mul result", alu_result, 16'h0000);
        chk("mul flags", flags_out, 3'b101);
        @(posedge clk); #1;
        chk("held add out_valid", out_valid, 1);
        chk("held add result", alu_result, 16'h0003);
        chk("held add flags", flags_out, 3'b000);
        @(negedge clk); in_valid = 0;
        @(posedge clk); #1;
        chk("after held add out_valid", out_valid, 0);

        run_md("divu by zero", DIVU, 16'h0000, 16'h1234, 16'hFFFF, 3'b110);
        run_md("divu 100/7", DIVU, 16'h0007, 16'h0064, 16'h000E, 3'b000);
        run_md("divu ffff/1", DIVU, 16'h0001, 16'hFFFF, 16'hFFFF, 3'b010);
        run_md("mul 12x34", MUL, 16'h0012, 16'h0034, 16'h03A8, 3'b000);
        run_md("mul ffx81", MUL, 16'h00FF, 16'h0081, 16'h807F, 3'b010);

        // Restore wins over a same-cycle completing ADD.
        @(negedge clk); set_op(ADD, 16'h0001, 16'h0001, 1'b1); flags_restore = 1; fwd_wb = 16'h0006;
        @(posedge clk); #1;
        chk("restore vs add flags", flags_out, 3'b110);
        chk("restore vs add result", alu_result, 16'h0002);
        @(negedge clk); in_valid = 0; flags_restore = 0;

        // Restore during BUSY takes effect at once; the completing MUL overwrites it.
        @(negedge clk); set_op(MUL, 16'h0003, 16'h0003, 1'b1);
        @(posedge clk);
        @(negedge clk); in_valid = 0;
        repeat (3) @(negedge clk);
        flags_restore = 1; fwd_wb = 16'h0003;
        @(posedge clk); #1;
        chk("restore in busy flags", flags_out, 3'b011);
        chk("restore in busy still busy", busy, 1);
        @(negedge clk); flags_restore = 0;
        wait_done(e);
        chk("mul 3x3 result", alu_result, 16'h0009);
        chk("mul 3x3 flags overwrite", flags_out, 3'b000);

        // MULDIV_EN=0 instance treats MUL as a single-cycle NOP.
        @(negedge clk); set_op(MUL, 16'h0003, 16'h0005, 1'b1);
        @(posedge clk); #1;
        chk("nomd out_valid", out_valid0, 1);
        chk("nomd result", res0, 16'h0005);
        chk("nomd busy", busy0, 0);
        chk("nomd sp_before", sp0, 16'h0003);
        chk("md busy", busy, 1);
        @(negedge clk); in_valid = 0;
        wait_done(e);
        chk("mul 3x5 latency", e, 17);
        chk("mul 3x5 result", alu_result, 16'h000F);

        // Asynchronous reset in the middle of a MUL.
        @(negedge clk); fwd_wb = 16'h0007; set_op(MUL, 16'h0100, 16'h0100, 1'b1);
        @(posedge clk);
        @(negedge clk); in_valid = 0; flags_restore = 1;
        @(posedge clk); #1;
        chk("pre-reset flags", flags_out, 3'b111);
        @(negedge clk); flags_restore = 0;
        repeat (5) @(posedge clk);
        #2; rst = 1; #1;
        chk("rst busy", busy, 0);
        chk("rst out_valid", out_valid, 0);
        chk("rst alu_result", alu_result, 0);
        chk("rst flags", flags_out, 0);
        chk("rst nomd flags", flags0, 0);
        @(negedge clk); rst = 0;
        ov = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk); #1;
            if (out_valid || busy) ov++;
        end
        chk("after reset no activity", ov, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
